// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encoding and sizing helper shared by the PLL lock supervisor
package pll_sup_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_sync2.sv
// rtl/pll_sync2.sv - generic two-flop synchronizer with synchronous active-high reset
module pll_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock qualifier with retry and sticky fail
// Optional macro PLL_SUP_LOSS_CNT_EN adds the saturating loss_cnt output.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 4
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   output logic                               pll_rst,
   output logic                               ready,
   output logic                               fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
`ifdef PLL_SUP_LOSS_CNT_EN
   output logic [7:0]                         loss_cnt,
`endif
   output logic [STATE_W-1:0]                 state
);

   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

   pll_state_t     state_q, state_d;
   logic [CW-1:0]  cnt;
   logic [RW-1:0]  retry_q, retry_d;
   logic           locked_s;
   logic           retry_now;

   pll_sync2 u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // The shared counter only runs in the bounded states, so it can never wrap.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= RESET_PLL;
         retry_q <= '0;
         cnt     <= '0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         if (state_d != state_q)
            cnt <= '0;
         else if (state_q == RESET_PLL || state_q == WAIT_LOCK || state_q == STABLE)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      retry_now = 1'b0;
      case (state_q)
         RESET_PLL: if (cnt == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (locked_s)
               state_d = STABLE;
            else if (cnt == CW'(LOCK_TIMEOUT - 1))
               retry_now = 1'b1;
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN:     if (!locked_s) retry_now = 1'b1;
         FAIL:    state_d = FAIL;
         default: state_d = RESET_PLL;
      endcase
      if (retry_now) begin
         if (retry_q == RW'(MAX_RETRIES)) begin
            state_d = FAIL;
         end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + RW'(1);
         end
      end
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge refclk) begin
      if (rst) begin
         pll_rst <= 1'b1;
         ready   <= 1'b0;
         fail    <= 1'b0;
      end else begin
         pll_rst <= (state_d == RESET_PLL) || (state_d == FAIL);
         ready   <= (state_d == RUN);
         fail    <= (state_d == FAIL);
      end
   end

   assign retry_cnt = retry_q;
   assign state     = state_q;

`ifdef PLL_SUP_LOSS_CNT_EN
   logic lost;
   assign lost = !locked_s && (state_q == STABLE || state_q == RUN);

   always_ff @(posedge refclk) begin
      if (rst)
         loss_cnt <= 8'd0;
      else if (lost && loss_cnt != 8'hFF)
         loss_cnt <= loss_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor against a timeline model
module tb_pll_lock_supervisor;

   localparam int RST_C = 4;
   localparam int TO_C  = 20;
   localparam int ST_C  = 8;
   localparam int MAX_R = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, ready, fail;
   logic [1:0] retry_cnt;
   logic [2:0] state;
`ifdef PLL_SUP_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif

   pll_lock_supervisor #(
      .RST_CYCLES    (RST_C),
      .LOCK_TIMEOUT  (TO_C),
      .STABLE_CYCLES (ST_C),
      .MAX_RETRIES   (MAX_R)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt),
`ifdef PLL_SUP_LOSS_CNT_EN
      .loss_cnt   (loss_cnt),
`endif
      .state      (state)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic       prst;
      logic       rdy;
      logic       fl;
      logic [1:0] rc;
      logic [7:0] loss;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Timeline model: phase plus the edge at which it was entered; lock seen two edges late.
   bit   lk_hist[$];
   int   k = 0;
   int   last_rst = 0;
   int   ph = 0;
   int   enter = 0;
   int   retries = 0;
   int   loss = 0;

   task automatic model_step(input bit r, input bit l);
      bit   ls;
      bit   go_retry;
      int   age;
      exp_t e;
      lk_hist.push_back(l);
      if (r) begin
         last_rst = k; ph = 0; enter = k; retries = 0; loss = 0;
      end else begin
         ls = (k - 2 > last_rst) ? lk_hist[k-2] : 1'b0;
         age = k - enter;
         go_retry = 1'b0;
         case (ph)
            0: if (age == RST_C) begin ph = 1; enter = k; end
            1: begin
               if (ls) begin ph = 2; enter = k; end
               else if (age == TO_C) go_retry = 1'b1;
            end
            2: begin
               if (!ls) begin
                  ph = 1; enter = k; loss = (loss < 255) ? loss + 1 : 255;
               end else if (age == ST_C) begin
                  ph = 3; enter = k; retries = 0;
               end
            end
            3: if (!ls) begin loss = (loss < 255) ? loss + 1 : 255; go_retry = 1'b1; end
            default: ;
         endcase
         if (go_retry) begin
            if (retries == MAX_R) ph = 4;
            else begin retries++; ph = 0; end
            enter = k;
         end
      end
      e.cyc  = k;
      e.st   = 3'(ph);
      e.prst = (ph == 0 || ph == 4);
      e.rdy  = (ph == 3);
      e.fl   = (ph == 4);
      e.rc   = 2'(retries);
`ifdef PLL_SUP_LOSS_CNT_EN
      e.loss = 8'(loss);
`else
      e.loss = 8'd0;
`endif
      exp_q.push_back(e);
      k++;
   endtask

   task automatic cycle(input bit r, input bit l);
      rst = r;
      pll_locked = l;
      model_step(r, l);
      @(negedge refclk);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [7:0] loss_act;
      forever begin
         @(posedge refclk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef PLL_SUP_LOSS_CNT_EN
            loss_act = loss_cnt;
`else
            loss_act = 8'd0;
`endif
            checks++;
            if (state !== e.st || pll_rst !== e.prst || ready !== e.rdy || fail !== e.fl ||
                retry_cnt !== e.rc || loss_act !== e.loss) begin
               errors++;
               $display("FAIL outputs cycle %0d: got st=%0d pll_rst=%b ready=%b fail=%b retry=%0d loss=%0d expected st=%0d pll_rst=%b ready=%b fail=%b retry=%0d loss=%0d",
                        e.cyc, state, pll_rst, ready, fail, retry_cnt, loss_act,
                        e.st, e.prst, e.rdy, e.fl, e.rc, e.loss);
            end
         end
      end
   end

   initial begin : stimulus
      int n;
      int sel;
      int len;
      repeat (3) cycle(1'b1, 1'b0);
      // lock 5 cycles after pll_rst falls, then a RUN loss and relock
      repeat (RST_C + 5) cycle(1'b0, 1'b0);
      repeat (20) cycle(1'b0, 1'b1);
      repeat (2) cycle(1'b0, 1'b0);
      repeat (30) cycle(1'b0, 1'b1);
      // single-cycle glitch while in STABLE
      repeat (1) cycle(1'b0, 1'b0);
      repeat (RST_C + 3) cycle(1'b0, 1'b0);
      repeat (4) cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      repeat (20) cycle(1'b0, 1'b1);
      // no lock at all: three attempts then FAIL
      repeat (3 * (RST_C + TO_C) + 10) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      // rst while in WAIT_LOCK with one retry consumed
      repeat (RST_C + TO_C + RST_C + 3) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b0);
      // randomized lock behaviour, including long outages and occasional resets
      n = 0;
      while (n < 5000) begin
         sel = $urandom_range(0, 99);
         if (sel < 3) begin
            len = $urandom_range(1, 3);
            repeat (len) cycle(1'b1, 1'($urandom_range(0, 1)));
         end else if (sel < 15) begin
            len = $urandom_range(40, 100);
            repeat (len) cycle(1'b0, 1'b0);
         end else begin
            len = $urandom_range(1, 12);
            repeat (len) cycle(1'b0, 1'b0);
            n += len;
            len = $urandom_range(1, 40);
            repeat (len) cycle(1'b0, 1'b1);
         end
         n += len;
      end
`ifdef PLL_SUP_LOSS_CNT_EN
      cycle(1'b1, 1'b0);
      repeat (300) begin
         repeat (2) cycle(1'b0, 1'b0);
         repeat (20) cycle(1'b0, 1'b1);
      end
`endif
      len = 0;
      while (exp_q.size() > 0 && len < 10) begin
         @(negedge refclk);
         len++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
`ifdef PLL_SUP_LOSS_CNT_EN
      checks++;
      if (loss_cnt !== 8'd255) begin
         errors++;
         $display("FAIL loss_saturate: got %0d required 255", loss_cnt);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
